// File: rtl/redun_mont_pkg.sv
// Shared types and helpers for the redundant-product resolve path.
// Default widths follow the upstream multi_mode_multiplier configuration.
package redun_mont_pkg;

  localparam int WRD_BITS = 16;
  localparam int NUM_WRDS = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef logic [WRD_BITS-1:0] canon_word_t;

  // One extra bit over the coefficient headroom keeps the running carry bounded.
  function automatic int carry_bits(int in_bits, int word_len);
    return in_bits - word_len + 1;
  endfunction

endpackage

// File: rtl/carry_resolve_slice.sv
// Combinational chain of WRDS_PER_CYC word+carry adders; the carry ripples
// from lane 0 (least significant) upward within one cycle.
module carry_resolve_slice
  import redun_mont_pkg::*;
#(
  parameter int WRDS_PER_CYC = 1,
  parameter int WORD_LEN     = WRD_BITS,
  parameter int IN_BITS      = WRD_BITS + 1,
  localparam int CARRY_BITS  = carry_bits(IN_BITS, WORD_LEN)
) (
  input  logic [WRDS_PER_CYC-1:0][IN_BITS-1:0]  coef,
  input  logic [CARRY_BITS-1:0]                 cin,
  output logic [WRDS_PER_CYC-1:0][WORD_LEN-1:0] word,
  output logic [CARRY_BITS-1:0]                 cout
);

  logic [WRDS_PER_CYC:0][CARRY_BITS-1:0] c;

  assign c[0] = cin;

  for (genvar k = 0; k < WRDS_PER_CYC; k++) begin : g_lane
    logic [IN_BITS:0] s;
    assign s        = {1'b0, coef[k]} + (IN_BITS+1)'(c[k]);
    assign word[k]  = s[WORD_LEN-1:0];
    assign c[k+1]   = s[IN_BITS:WORD_LEN];
  end

  assign cout = c[WRDS_PER_CYC];

endmodule

// File: rtl/redun_carry_resolve.sv
// Sequential carry-propagate of a redundant product into canonical words + carry-out.
// Optional CARRY_RESOLVE_ZERO_EN adds an o_zero flag tracked during RUN.
module redun_carry_resolve
  import redun_mont_pkg::*;
#(
  parameter int NUM_ELEMENTS = 2 * NUM_WRDS,
  parameter int WORD_LEN     = WRD_BITS,
  parameter int IN_BITS      = WRD_BITS + 1,
  parameter int WRDS_PER_CYC = 1,
  localparam int CARRY_BITS  = carry_bits(IN_BITS, WORD_LEN)
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_val,
  output logic                                  o_rdy,
  input  logic [NUM_ELEMENTS-1:0][IN_BITS-1:0]  i_dat,
  output logic                                  o_val,
  input  logic                                  i_rdy,
  output logic [NUM_ELEMENTS-1:0][WORD_LEN-1:0] o_dat,
`ifdef CARRY_RESOLVE_ZERO_EN
  output logic                                  o_zero,
`endif
  output logic [CARRY_BITS-1:0]                 o_carry
);

  localparam int NSTEP = NUM_ELEMENTS / WRDS_PER_CYC;
  localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int CW    = WRDS_PER_CYC * IN_BITS;
  localparam int OW    = WRDS_PER_CYC * WORD_LEN;

  state_e                                state, state_d;
  logic [SW-1:0]                         step;
  logic [NSTEP-1:0][CW-1:0]              in_q;
  logic [NSTEP-1:0][OW-1:0]              out_q;
  logic [NSTEP:0][OW-1:0]                out_ext;
  logic [CARRY_BITS-1:0]                 carry_q, cout;
  logic [WRDS_PER_CYC-1:0][WORD_LEN-1:0] words;
  logic                                  accept, last;

  assign accept  = i_val & o_rdy;
  assign last    = (step == SW'(NSTEP - 1));
  assign out_ext = {words, out_q};

  // Input and output are shift registers: lane group 0 is always the one being resolved.
  carry_resolve_slice #(
    .WRDS_PER_CYC (WRDS_PER_CYC),
    .WORD_LEN     (WORD_LEN),
    .IN_BITS      (IN_BITS)
  ) u_slice (
    .coef (in_q[0]),
    .cin  (carry_q),
    .word (words),
    .cout (cout)
  );

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last)   state_d = DONE;
      DONE:    if (i_rdy)  state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      step    <= '0;
      in_q    <= '0;
      out_q   <= '0;
      carry_q <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        in_q    <= i_dat;
        step    <= '0;
        carry_q <= '0;
      end else if (state == RUN) begin
        in_q    <= in_q >> CW;
        out_q   <= out_ext[NSTEP:1];
        step    <= step + 1'b1;
        carry_q <= cout;
      end
    end
  end

  assign o_rdy   = (state == IDLE);
  assign o_val   = (state == DONE);
  assign o_dat   = out_q;
  assign o_carry = carry_q;

`ifdef CARRY_RESOLVE_ZERO_EN
  // Sticky non-zero flag; only the final carry reaches the output.
  logic nz_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)               nz_q <= 1'b0;
    else if (accept)         nz_q <= 1'b0;
    else if (state == RUN)   nz_q <= nz_q | (|words) | (last & (|cout));
  end

  assign o_zero = (state == DONE) & ~nz_q;
`endif

endmodule

// File: tb/tb_redun_carry_resolve.sv
// Directed + random bench for redun_carry_resolve (4 x 5-bit coefficients -> 4 x 4-bit words).
// Build with CARRY_RESOLVE_ZERO_EN defined to also check o_zero.
module tb_redun_carry_resolve;
  localparam int NE = 4;
  localparam int WL = 4;
  localparam int IB = 5;
  localparam int CB = 2;

  typedef logic [NE-1:0][IB-1:0] din_t;
  typedef logic [NE*WL+CB-1:0]   res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, val, rdy_o, rdy_i, oval;
  logic val2, rdy2_o, rdy2_i, oval2;
  din_t dat;
  logic [NE-1:0][WL-1:0] odat, odat2;
  logic [CB-1:0] ocar, ocar2;
`ifdef CARRY_RESOLVE_ZERO_EN
  logic oz, oz2;
`endif

  res_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  redun_carry_resolve #(.NUM_ELEMENTS(NE), .WORD_LEN(WL), .IN_BITS(IB), .WRDS_PER_CYC(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_val(val), .o_rdy(rdy_o), .i_dat(dat),
    .o_val(oval), .i_rdy(rdy_i), .o_dat(odat),
`ifdef CARRY_RESOLVE_ZERO_EN
    .o_zero(oz),
`endif
    .o_carry(ocar));

  redun_carry_resolve #(.NUM_ELEMENTS(NE), .WORD_LEN(WL), .IN_BITS(IB), .WRDS_PER_CYC(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_val(val2), .o_rdy(rdy2_o), .i_dat(dat),
    .o_val(oval2), .i_rdy(rdy2_i), .o_dat(odat2),
`ifdef CARRY_RESOLVE_ZERO_EN
    .o_zero(oz2),
`endif
    .o_carry(ocar2));

  // Integer value of the redundant vector; its low bits are the canonical words.
  function automatic res_t model(din_t d);
    logic [31:0] t;
    t = '0;
    for (int i = 0; i < NE; i++) t = t + (32'(d[i]) << (i * WL));
    return res_t'(t);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single job on dut: accept, latency, optional backpressure, scoreboard compare.
  task automatic run_job(string tag, din_t d, int hold);
    int   lat;
    res_t held;
    res_t exp;
    lat = 0;
    while (!rdy_o && lat < 50) begin step(); lat++; end
    chk({tag, "_rdy"}, 32'(rdy_o), 32'd1);
    dat = d; val = 1'b1; rdy_i = (hold == 0);
    sb.push_back(model(d));
    step();
    val = 1'b0;
    lat = 1;
    while (!oval && lat < 50) begin step(); lat++; end
    chk({tag, "_lat"}, 32'(lat), 32'd5);
    held = {ocar, odat};
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_val"}, 32'(oval), 32'd1);
      chk({tag, "_hold_rdy"}, 32'(rdy_o), 32'd0);
      chk({tag, "_hold_dat"}, 32'({ocar, odat}), 32'(held));
    end
    rdy_i = 1'b1;
    exp = sb.pop_front();
    chk({tag, "_res"}, 32'({ocar, odat}), 32'(exp));
`ifdef CARRY_RESOLVE_ZERO_EN
    chk({tag, "_zero"}, 32'(oz), 32'(exp == '0));
`endif
    step();
    chk({tag, "_idle_rdy"}, 32'(rdy_o), 32'd1);
    chk({tag, "_drop_val"}, 32'(oval), 32'd0);
  endtask

  initial begin
    int   lat;
    din_t a, b;
    res_t exp;
    rst = 1'b1; val = 1'b0; rdy_i = 1'b1; val2 = 1'b0; rdy2_i = 1'b1; dat = '0;
    step();
    chk("rst_val", 32'(oval), 32'd0);
    chk("rst_dat", 32'({ocar, odat}), 32'd0);
`ifdef CARRY_RESOLVE_ZERO_EN
    chk("rst_zero", 32'(oz), 32'd0);
`endif
    rst = 1'b0;
    step();
    chk("rst_rdy", 32'(rdy_o), 32'd1);

    // Basic and backpressure
    run_job("basic", {5'h1F, 5'h1F, 5'h1F, 5'h1F}, 0);
    chk("basic_abs", 32'({ocar, odat}), 32'h2110F);
    run_job("bp", {5'h1F, 5'h1F, 5'h1F, 5'h1F}, 7);

    // Back-to-back with i_val held high
    a = {5'h04, 5'h03, 5'h02, 5'h01};
    b = {5'h10, 5'h10, 5'h10, 5'h10};
    dat = a; val = 1'b1;
    sb.push_back(model(a));
    step();
    dat = b;
    sb.push_back(model(b));
    lat = 1;
    while (!oval && lat < 50) begin step(); lat++; end
    exp = sb.pop_front();
    chk("b2b_first", 32'({ocar, odat}), 32'(exp));
    chk("b2b_first_abs", 32'({ocar, odat}), 32'h04321);
    step();
    chk("b2b_idle", 32'(rdy_o), 32'd1);
    step();
    chk("b2b_accepted", 32'(rdy_o), 32'd0);
    val = 1'b0;
    lat = 1;
    while (!oval && lat < 50) begin step(); lat++; end
    chk("b2b_lat", 32'(lat), 32'd5);
    exp = sb.pop_front();
    chk("b2b_second", 32'({ocar, odat}), 32'(exp));
    chk("b2b_second_abs", 32'({ocar, odat}), 32'h11110);
    step();

    // Reset two cycles into RUN
    dat = {5'h11, 5'h07, 5'h1A, 5'h05}; val = 1'b1;
    step();
    val = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_val", 32'(oval), 32'd0);
    chk("mid_rst_dat", 32'({ocar, odat}), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("mid_rst_rdy", 32'(rdy_o), 32'd1);
    run_job("after_rst", {5'h1F, 5'h1F, 5'h1F, 5'h1F}, 0);

    // Two words per cycle
    dat = {5'h1F, 5'h1F, 5'h1F, 5'h1F}; val2 = 1'b1;
    step();
    val2 = 1'b0;
    lat = 1;
    while (!oval2 && lat < 50) begin step(); lat++; end
    chk("w2_lat", 32'(lat), 32'd3);
    chk("w2_res", 32'({ocar2, odat2}), 32'h2110F);
`ifdef CARRY_RESOLVE_ZERO_EN
    chk("w2_zero", 32'(oz2), 32'd0);
`endif
    step();
    chk("w2_idle", 32'(rdy2_o), 32'd1);

    // Zero input and pure carry-out
    run_job("zero_in", '0, 0);
    chk("zero_abs", 32'({ocar, odat}), 32'd0);
    run_job("top_carry", {5'h10, 5'h00, 5'h00, 5'h00}, 1);
    chk("top_carry_abs", 32'({ocar, odat}), 32'h10000);

    // Random jobs with random backpressure
    for (int j = 0; j < 200; j++) begin
      din_t r;
      for (int i = 0; i < NE; i++) r[i] = IB'($urandom);
      run_job("rand", r, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
